// File: rtl/hazard_mem_controller.sv
// Hazard unit and data-memory sequencer for the 5-stage RV32I pipeline; forwarding/stall/flush are combinational.
// A pending memory access freezes F/D/E/M and bubbles W until mem_ack or timeout; mem_req is held until then.
module hazard_mem_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int TMO_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ABORT
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_acc_m;
    logic lw_stall;
    logic mem_stall;
    logic mem_req_raw;
    logic abort_cyc;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
        ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
        mem_acc_m = MemWriteM | (ResultSrcM == 2'b01);
        lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        mem_req_raw = 1'b0;
        mem_stall   = 1'b0;
        abort_cyc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d       = '0;
                mem_req_raw = mem_acc_m;
                mem_stall   = mem_acc_m & ~mem_ack;
                if (mem_stall) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_req_raw = 1'b1;
                tmo_d       = tmo_q + TMO_W'(1);
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                // The faulting access is dropped: W is bubbled and MemAccM is ignored.
                abort_cyc = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A pending memory access overrides load-use and branch handling; E is held so those re-resolve later.
    always_comb begin
        StallF = lw_stall;
        StallD = lw_stall;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
        FlushW = abort_cyc;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    always_comb begin
        mem_err_d   = mem_err_q | abort_cyc;
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_req   = mem_req_raw & rst_n;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_mem_controller.sv
// Bench for hazard_mem_controller: directed scenarios and randomized traffic against a cycle-level reference model.
// A second instance with a 2-bit counter shares all inputs to exercise stall_cnt saturation.
module tb_hazard_mem_controller;
    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE, ResultSrcM;
    logic       MemWriteM, RegWriteM, RegWriteW, PCSrcE, mem_ack;

    logic        mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cnt;

    logic       s_mem_req, s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_FlushW, s_mem_err;
    logic [1:0] s_ForwardAE, s_ForwardBE;
    logic [1:0] s_stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_mem_controller #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .mem_ack(mem_ack), .mem_req(mem_req), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    hazard_mem_controller #(.MEM_TIMEOUT(T), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .mem_ack(mem_ack), .mem_req(s_mem_req), .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .FlushW(s_FlushW), .mem_err(s_mem_err),
        .stall_cnt(s_stall_cnt)
    );

    // Reference model: "waiting" tracks an outstanding access and how many wait cycles it has used.
    bit          m_waiting, m_abort, m_err;
    int          m_waited, m_stalls;
    bit          e_mem_stall, e_stallf;
    logic [30:0] exp_vec;

    function automatic logic [30:0] obs();
        return {mem_req, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, mem_err, stall_cnt, s_stall_cnt};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_abort = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    endtask

    task automatic model_eval();
        bit acc, lw, req, ms, sf, se, fd, fe, fw;
        acc = MemWriteM || (ResultSrcM == 2'b01);
        lw  = (ResultSrcE == 2'b01) && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
        if (m_abort) begin
            req = 0; ms = 0;
        end else if (m_waiting) begin
            req = 1; ms = !mem_ack;
        end else begin
            req = acc; ms = acc && !mem_ack;
        end
        if (ms) begin
            sf = 1; se = 1; fd = 0; fe = 0; fw = 1;
        end else begin
            sf = lw; se = 0; fd = PCSrcE; fe = lw || PCSrcE; fw = m_abort;
        end
        e_mem_stall = ms;
        e_stallf    = sf;
        exp_vec = {req, ref_fwd(Rs1E), ref_fwd(Rs2E), sf, sf, se, se, fd, fe, fw, m_err,
                   16'(m_stalls > 65535 ? 65535 : m_stalls), 2'(m_stalls > 3 ? 3 : m_stalls)};
    endtask

    task automatic advance();
        if (e_stallf) m_stalls++;
        if (m_abort) begin
            m_err = 1; m_abort = 0;
        end else if (m_waiting) begin
            if (mem_ack) m_waiting = 0;
            else if (m_waited == T - 1) begin
                m_waiting = 0; m_abort = 1;
            end else m_waited++;
        end else if (e_mem_stall) begin
            m_waiting = 1; m_waited = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; ResultSrcM = 0; MemWriteM = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; mem_ack = 0;
    endtask

    task automatic apply_reset();
        set_idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_eval();
        checks++;
        if (obs() !== exp_vec) begin
            errors++; $display("FAIL reset_vec: got %h expected %h", obs(), exp_vec);
        end
        ResultSrcM = 2'b01;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req);
        end
        set_idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forwarding();
        logic [4:0] tbl [4][6];
        logic [1:0] ea [4];
        logic [1:0] eb [4];
        tbl[0] = '{5'd1, 5'd5, 5'd1, 5'd5, 5'd5, 5'd9}; ea[0] = 2'b10; eb[0] = 2'b00;
        tbl[1] = '{5'd1, 5'd4, 5'd1, 5'd5, 5'd4, 5'd5}; ea[1] = 2'b10; eb[1] = 2'b01;
        tbl[2] = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0}; ea[2] = 2'b00; eb[2] = 2'b00;
        tbl[3] = '{5'd0, 5'd5, 5'd1, 5'd5, 5'd5, 5'd5}; ea[3] = 2'b01; eb[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            set_idle();
            RegWriteM = tbl[i][0][0]; RdM = tbl[i][1]; RegWriteW = tbl[i][2][0];
            RdW = tbl[i][3]; Rs1E = tbl[i][4]; Rs2E = tbl[i][5];
            @(negedge clk);
            model_eval();
            checks++;
            if ({ForwardAE, ForwardBE} !== {ea[i], eb[i]}) begin
                errors++;
                $display("FAIL fwd row%0d: got A=%b B=%b expected A=%b B=%b", i, ForwardAE, ForwardBE, ea[i], eb[i]);
            end
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL fwd_vec row%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_load_use();
        logic [3:0] exp4 [3];
        exp4[0] = 4'b1110; exp4[1] = 4'b1111; exp4[2] = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            ResultSrcE = 2'b01; Rs2D = 5'd3;
            RdE    = (i == 2) ? 5'd0 : 5'd3;
            Rs1D   = (i == 2) ? 5'd0 : 5'd7;
            PCSrcE = (i == 1);
            @(negedge clk);
            model_eval();
            checks++;
            if ({StallF, StallD, FlushE, FlushD} !== exp4[i]) begin
                errors++;
                $display("FAIL load_use row%0d: got %b expected %b", i, {StallF, StallD, FlushE, FlushD}, exp4[i]);
            end
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL load_use_vec row%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            ResultSrcM = 2'b01;
            mem_ack    = (i == 3);
            @(negedge clk);
            model_eval();
            checks++;
            if ({StallF, StallD, StallE, StallM, FlushW, mem_req} !== {{5{i < 3}}, 1'b1}) begin
                errors++;
                $display("FAIL mem_wait cyc%0d: got %b expected %b", i,
                         {StallF, StallD, StallE, StallM, FlushW, mem_req}, {{5{i < 3}}, 1'b1});
            end
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL mem_wait_vec cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
        set_idle();
        @(negedge clk);
        model_eval();
        checks++;
        if ({mem_req, StallF, stall_cnt} !== {1'b0, 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL mem_wait_end: got req=%b stall=%b cnt=%0d expected 0 0 3", mem_req, StallF, stall_cnt);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [3:0] rows [3];
        rows[0] = 4'b1010; rows[1] = 4'b0101; rows[2] = 4'b0110;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            {MemWriteM, ResultSrcM[0], mem_ack} = rows[i][3:1];
            @(negedge clk);
            model_eval();
            checks++;
            if ({StallF, mem_req} !== {rows[i][0], 1'b1}) begin
                errors++;
                $display("FAIL b2b cyc%0d: got stall=%b req=%b expected stall=%b req=1", i, StallF, mem_req, rows[i][0]);
            end
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL b2b_vec cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++; $display("FAIL b2b_cnt: got %0d expected 1", stall_cnt);
        end
        model_eval();
        advance();
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            ResultSrcM = 2'b01;
            mem_ack    = 0;
            @(negedge clk);
            model_eval();
            checks++;
            if (i < 5 && {StallF, StallM, mem_req, FlushW} !== 4'b1111) begin
                errors++; $display("FAIL timeout_wait cyc%0d: got %b expected 1111", i, {StallF, StallM, mem_req, FlushW});
            end else if (i == 5 && {StallF, StallE, StallM, mem_req, FlushW, mem_err} !== 6'b000010) begin
                errors++;
                $display("FAIL timeout_abort: got %b expected 000010", {StallF, StallE, StallM, mem_req, FlushW, mem_err});
            end
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL timeout_vec cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
        set_idle();
        @(negedge clk);
        model_eval();
        checks++;
        if ({mem_err, stall_cnt, s_stall_cnt} !== {1'b1, 16'd5, 2'd3}) begin
            errors++;
            $display("FAIL timeout_after: got err=%b cnt=%0d sat=%0d expected 1 5 3", mem_err, stall_cnt, s_stall_cnt);
        end
        advance();
        ResultSrcM = 2'b01; mem_ack = 1;
        @(negedge clk);
        model_eval();
        checks++;
        if (obs() !== exp_vec) begin
            errors++; $display("FAIL timeout_ok_vec: got %h expected %h", obs(), exp_vec);
        end
        advance();
        set_idle();
        @(negedge clk);
        model_eval();
        checks++;
        if (mem_err !== 1'b1) begin
            errors++; $display("FAIL sticky_err: got %b expected 1", mem_err);
        end
        advance();
    endtask

    task automatic test_async_reset();
        ResultSrcM = 2'b01; mem_ack = 0;
        @(negedge clk);
        model_eval();
        advance();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({mem_req, mem_err, stall_cnt, s_stall_cnt} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got req=%b err=%b cnt=%0d sat=%0d expected all 0",
                     mem_req, mem_err, stall_cnt, s_stall_cnt);
        end
        model_reset();
        set_idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            ResultSrcM = (i < 2) ? 2'b01 : 2'b00;
            mem_ack    = (i == 1);
            @(negedge clk);
            model_eval();
            checks++;
            if (StallF !== (i == 0)) begin
                errors++; $display("FAIL post_reset cyc%0d: got stall=%b expected %b", i, StallF, i == 0);
            end
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL post_reset_vec cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            ResultSrcM = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
            MemWriteM  = ($urandom_range(0, 5) == 0);
            RegWriteM  = 1'($urandom); RegWriteW = 1'($urandom);
            PCSrcE     = ($urandom_range(0, 4) == 0);
            mem_ack    = ($urandom_range(0, 4) < 2);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== exp_vec) begin
                errors++; $display("FAIL random cyc%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        set_idle();
        rst_n = 0;
        model_reset();
        #3;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
